kbd_rx: RTL

KBD_RX -- requirements
Module: kbd_rx

---
 rtl/kbd_rx.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/kbd_rx.sv
// kbd_rx: PS/2-style serial receiver with input synchronizers, clock glitch filter and frame timeout
module kbd_rx #(
    parameter int FILTER  = 4,
    parameter int TIMEOUT = 2000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       kbd_clk,
    input  logic       kbd_dat,
    output logic [7:0] data,
    output logic       valid,
    output logic       perr,
    output logic       ferr,
    output logic       tout,
    output logic       busy
);
    localparam int FW = $clog2(FILTER + 1);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] DATA   = 2'd1;
    localparam logic [1:0] PARITY = 2'd2;
    localparam logic [1:0] STOP   = 2'd3;

    logic          clk_s1, clk_s2, dat_s1, dat_s2;
    logic          fclk, fclk_q, armed;
    logic [1:0]    flush;
    logic [FW-1:0] fcnt;
    logic [TW-1:0] tcnt;
    logic [1:0]    state;
    logic [2:0]    bcnt;
    logic [7:0]    sr;
    logic          par;
    logic          fe;

    // Falling edges only count once the filtered clock has been seen high after reset.
    assign fe   = fclk_q & ~fclk & armed;
    assign busy = state != IDLE;

    // Two-flop synchronizers for both serial lines, idling high.
    always_ff @(posedge clk) begin
        if (reset) begin
            clk_s1 <= 1'b1;
            clk_s2 <= 1'b1;
            dat_s1 <= 1'b1;
            dat_s2 <= 1'b1;
        end else begin
            clk_s1 <= kbd_clk;
            clk_s2 <= clk_s1;
            dat_s1 <= kbd_dat;
            dat_s2 <= dat_s1;
        end
    end

    // Accept a new kbd_clk level only after it has persisted FILTER cycles.
    always_ff @(posedge clk) begin
        if (reset) begin
            fclk   <= 1'b1;
            fclk_q <= 1'b1;
            fcnt   <= '0;
        end else begin
            fclk_q <= fclk;
            if (clk_s2 == fclk) begin
                fcnt <= '0;
            end else if (fcnt == FW'(FILTER - 1)) begin
                fclk <= clk_s2;
                fcnt <= '0;
            end else begin
                fcnt <= fcnt + 1'b1;
            end
        end
    end

    // Arm edge detection once the synchronizer has flushed and the line is seen high.
    always_ff @(posedge clk) begin
        if (reset) begin
            flush <= 2'd0;
            armed <= 1'b0;
        end else begin
            if (flush != 2'd2) flush <= flush + 2'd1;
            if (flush == 2'd2 && fclk && clk_s2) armed <= 1'b1;
        end
    end

    // Frame state machine, timeout watchdog and result pulses.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            bcnt  <= 3'd0;
            sr    <= 8'h00;
            par   <= 1'b0;
            tcnt  <= '0;
            data  <= 8'h00;
            valid <= 1'b0;
            perr  <= 1'b0;
            ferr  <= 1'b0;
            tout  <= 1'b0;
        end else begin
            valid <= 1'b0;
            perr  <= 1'b0;
            ferr  <= 1'b0;
            tout  <= 1'b0;
            if (state == IDLE || fe) begin
                tcnt <= '0;
            end else if (tcnt == TW'(TIMEOUT - 1)) begin
                tcnt  <= '0;
                tout  <= 1'b1;
                state <= IDLE;
            end else begin
                tcnt <= tcnt + 1'b1;
            end
            if (fe) begin
                case (state)
                    IDLE: begin
                        if (!dat_s2) begin
                            state <= DATA;
                            bcnt  <= 3'd0;
                        end
                    end
                    DATA: begin
                        sr    <= {dat_s2, sr[7:1]};
                        bcnt  <= bcnt + 3'd1;
                        state <= bcnt == 3'd7 ? PARITY : DATA;
                    end
                    PARITY: begin
                        par   <= dat_s2;
                        state <= STOP;
                    end
                    default: begin
                        state <= IDLE;
                        if (!dat_s2) begin
                            ferr <= 1'b1;
                        end else if (^{sr, par}) begin
                            data  <= sr;
                            valid <= 1'b1;
                        end else begin
                            perr <= 1'b1;
                        end
                    end
                endcase
            end
        end
    end
endmodule
